nibbler_control: RTL
====================

Name: nibbler_control

Overview:
Multi-cycle fetch/decode/execute sequencer for the 4-bit nibble datapath.
- Owns the program counter, instruction register and carry/zero flag register.
- Fetches 8-bit program words from a synchronous ROM.
- Drives the 3-bit ALU opcode, B-operand select and write strobes for accumulator, data RAM and output port.
- Resolves conditional jumps from the registered flags.

Parameters:
PC_W, 12, program and data address width
RESET_PC, 0, PC value loaded on reset

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high
prog_addr  out  PC_W  ROM address; equals the PC register
prog_data  in  8  ROM word, valid one cycle after prog_addr
data_addr  out  PC_W  RAM address register
data_we  out  1  RAM write strobe; write data is the ALU OUT result
alu_opcode  out  3  OUT=000 CMP=001 LD=010 ADD=011 NOR=100
alu_b_sel  out  2  0=immediate, 1=RAM read data, 2=input port
alu_imm  out  4  ir[3:0]
alu_carry  in  1  ALU carry
alu_zero  in  1  ALU zero
acc_we  out  1  accumulator write strobe
out_we  out  1  output-port write strobe
flag_c  out  1  registered carry flag
flag_z  out  1  registered zero flag
instr_done  out  1  one-cycle pulse in the EXEC cycle of every instruction

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values: state=S_FETCH, pc=RESET_PC, ir=0, addr_lo=0, data_addr=0, flags=0. All strobes (data_we, acc_we, out_we, instr_done) are 0. alu_opcode=000, alu_b_sel=0.
- Reset asserted mid-instruction aborts it: no strobe in that cycle, and the state above is applied on that edge.
- Instruction word is {op[7:4], imm[3:0]}. Opcode map:
  - Two-word ops: 0 JC, 1 JNC, 2 JZ, 3 JNZ, 4 J, 6 CMPM, 9 LD, 10 ST, 13 ADDM, 15 NORM. The second word is addr_lo[7:0], and target = {imm, addr_lo}.
  - One-word ops: 5 CMPI, 7 LIT, 8 IN, 11 OUT, 12 ADDI, 14 NORI.
- State machine:
  - S_FETCH: pc<=pc+1 → S_DECODE.
  - S_DECODE: ir<=prog_data. If the op is two-word, pc<=pc+1 → S_ADDR; otherwise → S_EXEC.
  - S_ADDR: addr_lo<=prog_data and data_addr<={ir[3:0],prog_data}. Memory-read ops (CMPM, LD, ADDM, NORM) → S_MEM; otherwise → S_EXEC.
  - S_MEM: wait one cycle for the RAM read → S_EXEC.
  - S_EXEC: assert the op's strobes for exactly one cycle, plus instr_done → S_FETCH.
- Latency:
  - One-word ops: 3 cycles.
  - Jumps and ST: 4 cycles.
  - Memory-read ops: 5 cycles.
- ALU control in S_EXEC (outside EXEC: opcode=000, strobes=0):
  - CMP ops: opcode=CMP, no acc write.
  - LIT, IN, LD: opcode=LD with b_sel=imm, in or mem respectively; acc_we=1.
  - ADD ops: opcode=ADD; NOR ops: opcode=NOR; acc_we=1 for both.
  - ST: opcode=OUT, data_we=1.
  - OUT: opcode=OUT, out_we=1.
- Flags: updated from alu_carry/alu_zero at the end of S_EXEC for CMP, ADD and NOR ops only; held for all others.
- Jumps in S_EXEC:
  - pc<={imm,addr_lo} when the condition on the current registered flags holds (JC c=1, JNC c=0, JZ z=1, JNZ z=0, J always).
  - Not taken: pc is unchanged, already pointing past the two words.
- PC wraps modulo 2^PC_W. A two-word op whose first word sits at the top address takes its second word from address 0.

Decomposition:
- Package nibbler_pkg: ALU opcode constants (shared with the ALU), 4-bit instruction opcode constants, b_sel constants, state enum typedef, helper functions is_two_word(op) and is_mem_read(op).
- Single module. The decoder is a combinational always block inside it; no sub-module.

Test Plan:
- Reset: pulse reset for 2 cycles with ROM[0]=0x73 (LIT 3) → cycle 3: acc_we=1, alu_opcode=010, b_sel=0, alu_imm=3, instr_done=1. prog_addr=0 during reset.
- ADDI carry: LIT F then ADDI 1 (0xC1), ALU returns carry=1 zero=1 → flag_c=1, flag_z=1 after the ADDI EXEC. Following JC to 0x123 (0x01,0x23) → prog_addr=0x123 four cycles later.
- JNZ not taken: flag_z=1, JNZ 0x0AB at pc=0x010 → pc=0x012 after EXEC. Flags unchanged.
- LD mem: LD 0x456 (0x94,0x56) → data_addr=0x456 in S_MEM. EXEC at cycle 5 with b_sel=1, acc_we=1. Flags unchanged.
- ST/OUT: ST 0x7FF → data_we one cycle with opcode=000. OUT (0xB0) → out_we=1, data_we=0.
- Corner cases:
  - reset asserted during S_MEM → no acc_we, pc=RESET_PC next cycle.
  - two-word op at pc=0xFFF → operand read from address 0, pc=0x001 after.

Source files
------------

// File: rtl/nibbler_pkg.sv
// Shared encodings for the nibble datapath: ALU opcodes, instruction opcodes,
// B-operand selects, sequencer states and instruction-class helpers.
package nibbler_pkg;

  localparam logic [2:0] ALU_OUT = 3'b000;
  localparam logic [2:0] ALU_CMP = 3'b001;
  localparam logic [2:0] ALU_LD  = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;

  localparam logic [3:0] OP_JC   = 4'd0;
  localparam logic [3:0] OP_JNC  = 4'd1;
  localparam logic [3:0] OP_JZ   = 4'd2;
  localparam logic [3:0] OP_JNZ  = 4'd3;
  localparam logic [3:0] OP_J    = 4'd4;
  localparam logic [3:0] OP_CMPI = 4'd5;
  localparam logic [3:0] OP_CMPM = 4'd6;
  localparam logic [3:0] OP_LIT  = 4'd7;
  localparam logic [3:0] OP_IN   = 4'd8;
  localparam logic [3:0] OP_LD   = 4'd9;
  localparam logic [3:0] OP_ST   = 4'd10;
  localparam logic [3:0] OP_OUT  = 4'd11;
  localparam logic [3:0] OP_ADDI = 4'd12;
  localparam logic [3:0] OP_ADDM = 4'd13;
  localparam logic [3:0] OP_NORI = 4'd14;
  localparam logic [3:0] OP_NORM = 4'd15;

  localparam logic [1:0] BSEL_IMM = 2'd0;
  localparam logic [1:0] BSEL_MEM = 2'd1;
  localparam logic [1:0] BSEL_IN  = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ADDR,
    S_MEM,
    S_EXEC
  } state_t;

  function automatic logic is_two_word(input logic [3:0] op);
    case (op)
      OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_J,
      OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NORM: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem_read(input logic [3:0] op);
    case (op)
      OP_CMPM, OP_LD, OP_ADDM, OP_NORM: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/nibbler_control.sv
// Fetch/decode/execute sequencer: owns PC, IR and flags, reads the program ROM
// and drives the ALU controls and write strobes for one instruction at a time.
module nibbler_control
  import nibbler_pkg::*;
#(
  parameter int              PC_W     = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock,
  input  logic            reset,
  output logic [PC_W-1:0] prog_addr,
  input  logic [7:0]      prog_data,
  output logic [PC_W-1:0] data_addr,
  output logic            data_we,
  output logic [2:0]      alu_opcode,
  output logic [1:0]      alu_b_sel,
  output logic [3:0]      alu_imm,
  input  logic            alu_carry,
  input  logic            alu_zero,
  output logic            acc_we,
  output logic            out_we,
  output logic            flag_c,
  output logic            flag_z,
  output logic            instr_done
);

  state_t          r_state, w_state_next;
  logic [PC_W-1:0] r_pc, w_pc_next;
  logic [7:0]      r_ir, w_ir_next;
  logic [7:0]      r_addr_lo, w_addr_lo_next;
  logic [PC_W-1:0] r_data_addr, w_data_addr_next;
  logic            r_flag_c, w_flag_c_next;
  logic            r_flag_z, w_flag_z_next;

  logic [3:0]      w_op;
  logic [PC_W-1:0] w_target;
  logic [2:0]      w_alu_opcode;
  logic [1:0]      w_b_sel;
  logic            w_acc_we, w_data_we, w_out_we, w_done, w_upd_flags;

  assign w_op     = r_ir[7:4];
  assign w_target = PC_W'({r_ir[3:0], r_addr_lo});

  always_comb begin
    w_state_next     = r_state;
    w_pc_next        = r_pc;
    w_ir_next        = r_ir;
    w_addr_lo_next   = r_addr_lo;
    w_data_addr_next = r_data_addr;
    w_flag_c_next    = r_flag_c;
    w_flag_z_next    = r_flag_z;
    w_alu_opcode     = ALU_OUT;
    w_b_sel          = BSEL_IMM;
    w_acc_we         = 1'b0;
    w_data_we        = 1'b0;
    w_out_we         = 1'b0;
    w_done           = 1'b0;
    w_upd_flags      = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_pc_next    = r_pc + PC_W'(1);
        w_state_next = S_DECODE;
      end
      S_DECODE: begin
        w_ir_next = prog_data;
        if (is_two_word(prog_data[7:4])) begin
          w_pc_next    = r_pc + PC_W'(1);
          w_state_next = S_ADDR;
        end else begin
          w_state_next = S_EXEC;
        end
      end
      S_ADDR: begin
        w_addr_lo_next   = prog_data;
        w_data_addr_next = PC_W'({r_ir[3:0], prog_data});
        w_state_next     = is_mem_read(w_op) ? S_MEM : S_EXEC;
      end
      S_MEM: w_state_next = S_EXEC;
      S_EXEC: begin
        w_done       = 1'b1;
        w_state_next = S_FETCH;
        case (w_op)
          OP_JC:   if (r_flag_c)  w_pc_next = w_target;
          OP_JNC:  if (!r_flag_c) w_pc_next = w_target;
          OP_JZ:   if (r_flag_z)  w_pc_next = w_target;
          OP_JNZ:  if (!r_flag_z) w_pc_next = w_target;
          OP_J:    w_pc_next = w_target;
          OP_CMPI: begin w_alu_opcode = ALU_CMP; w_upd_flags = 1'b1; end
          OP_CMPM: begin w_alu_opcode = ALU_CMP; w_b_sel = BSEL_MEM; w_upd_flags = 1'b1; end
          OP_LIT:  begin w_alu_opcode = ALU_LD; w_acc_we = 1'b1; end
          OP_IN:   begin w_alu_opcode = ALU_LD; w_b_sel = BSEL_IN; w_acc_we = 1'b1; end
          OP_LD:   begin w_alu_opcode = ALU_LD; w_b_sel = BSEL_MEM; w_acc_we = 1'b1; end
          OP_ST:   w_data_we = 1'b1;
          OP_OUT:  w_out_we  = 1'b1;
          OP_ADDI: begin w_alu_opcode = ALU_ADD; w_acc_we = 1'b1; w_upd_flags = 1'b1; end
          OP_ADDM: begin w_alu_opcode = ALU_ADD; w_b_sel = BSEL_MEM; w_acc_we = 1'b1; w_upd_flags = 1'b1; end
          OP_NORI: begin w_alu_opcode = ALU_NOR; w_acc_we = 1'b1; w_upd_flags = 1'b1; end
          OP_NORM: begin w_alu_opcode = ALU_NOR; w_b_sel = BSEL_MEM; w_acc_we = 1'b1; w_upd_flags = 1'b1; end
          default: ;
        endcase
        if (w_upd_flags) begin
          w_flag_c_next = alu_carry;
          w_flag_z_next = alu_zero;
        end
      end
      default: w_state_next = S_FETCH;
    endcase

    // A reset landing on the EXEC cycle aborts the instruction with no side effects.
    if (reset) begin
      w_alu_opcode = ALU_OUT;
      w_b_sel      = BSEL_IMM;
      w_acc_we     = 1'b0;
      w_data_we    = 1'b0;
      w_out_we     = 1'b0;
      w_done       = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      r_addr_lo   <= '0;
      r_data_addr <= '0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_ir        <= w_ir_next;
      r_addr_lo   <= w_addr_lo_next;
      r_data_addr <= w_data_addr_next;
      r_flag_c    <= w_flag_c_next;
      r_flag_z    <= w_flag_z_next;
    end
  end

  assign prog_addr  = r_pc;
  assign data_addr  = r_data_addr;
  assign alu_imm    = r_ir[3:0];
  assign flag_c     = r_flag_c;
  assign flag_z     = r_flag_z;
  assign alu_opcode = w_alu_opcode;
  assign alu_b_sel  = w_b_sel;
  assign acc_we     = w_acc_we;
  assign data_we    = w_data_we;
  assign out_we     = w_out_we;
  assign instr_done = w_done;

endmodule
